// File: rtl/mac_array_seq.sv
// mac_array_seq: sequencer feeding one mac_array instance.
// Per job it loads the weights, lets the skewed load settle, arms the
// array, streams the activation vectors, and then waits for the array's
// output-valid pulses before it pulses done.
// Optional feature: define MAC_SEQ_WATCHDOG_EN to enable a drain-phase
// watchdog. It sets err[1] after TIMEOUT cycles in DRAIN. When the macro
// is undefined, DRAIN waits indefinitely and err[1] stays 0.

module mac_array_seq #(
  parameter int bw      = 2,
  parameter int row     = 2,
  parameter int col     = 2,
  parameter int nij_bw  = 8,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [nij_bw-1:0]     nij,
  input  logic [row*bw*2-1:0]   wt_data,
  input  logic                  wt_valid,
  output logic                  wt_ready,
  input  logic [row*bw*2-1:0]   act_data,
  input  logic                  act_valid,
  output logic                  act_ready,
  output logic [2:0]            inst_w,
  output logic [row*bw*2-1:0]   in_w,
  input  logic [col-1:0]        valid,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err
);

  localparam int WCW = $clog2(2*col + 1);
  localparam int FCW = (row > 1) ? $clog2(row + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_ARM,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state;
  logic                mode_r;
  logic [nij_bw-1:0]   nij_r;
  logic [WCW-1:0]      wcnt;
  logic [FCW-1:0]      fcnt;
  logic [nij_bw-1:0]   scnt;
  logic [nij_bw-1:0]   out_cnt;
  logic [nij_bw-1:0]   out_cnt_nxt;
  logic [1:0]          err_r;
  logic [WCW-1:0]      wl;
  logic                counting;
  logic                unused_ok;

`ifdef MAC_SEQ_WATCHDOG_EN
  localparam int DCW = $clog2(TIMEOUT + 1);
  logic [DCW-1:0]      dcnt;
  assign unused_ok = ^valid;
`else
  assign unused_ok = ^{valid, TIMEOUT > 0};
`endif

  // Weight words per job: two passes of the columns in 2-bit mode, one in 4-bit mode.
  assign wl = mode_r ? WCW'(col) : WCW'(2*col);

  // Output pulses are counted from the ARM cycle through DRAIN.
  assign counting = (state == S_ARM) || (state == S_STREAM) || (state == S_DRAIN);

  // Saturating count of array output-valid pulses seen on the last column.
  always_comb begin
    // NOTE: default first, so that every path assigns a value and no latch is inferred.
    out_cnt_nxt = out_cnt;
    if (counting && valid[col-1] && (out_cnt != nij_r)) begin
      out_cnt_nxt = out_cnt + 1'b1;
    end
  end

  // These are decoded directly from the state register, so no input reaches them combinationally.
  assign wt_ready  = (state == S_LOAD);
  assign act_ready = (state == S_STREAM);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = err_r;

  // Job FSM. inst_w and in_w are registered, so the array sees each state's
  // action one cycle after that state's cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register updates from pre-edge values.
    if (reset) begin
      state   <= S_IDLE;
      mode_r  <= 1'b0;
      nij_r   <= '0;
      wcnt    <= '0;
      fcnt    <= '0;
      scnt    <= '0;
      out_cnt <= '0;
      err_r   <= '0;
      inst_w  <= '0;
      in_w    <= '0;
`ifdef MAC_SEQ_WATCHDOG_EN
      dcnt    <= '0;
`endif
    end else begin
      inst_w  <= {mode_r, 2'b00};
      in_w    <= '0;
      out_cnt <= out_cnt_nxt;

      case (state)
        S_IDLE: begin
          inst_w <= '0;
          if (start) begin
            mode_r  <= mode;
            nij_r   <= nij;
            err_r   <= '0;
            wcnt    <= '0;
            fcnt    <= '0;
            scnt    <= '0;
            out_cnt <= '0;
`ifdef MAC_SEQ_WATCHDOG_EN
            dcnt    <= '0;
`endif
            state   <= S_LOAD;
          end
        end

        S_LOAD: begin
          // A missing word drops the load bit, so the array holds its weights.
          if (wt_valid) begin
            inst_w <= {mode_r, 2'b01};
            in_w   <= wt_data;
            if (wcnt == wl - 1'b1) begin
              wcnt  <= '0;
              state <= S_FLUSH;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end

        S_FLUSH: begin
          // Idle for row cycles so the skewed load reaches the last row.
          if (fcnt == FCW'(row - 1)) begin
            fcnt  <= '0;
            state <= S_ARM;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end

        S_ARM: begin
          inst_w <= {mode_r, 2'b10};
          state  <= (nij_r == '0) ? S_DONE : S_STREAM;
        end

        S_STREAM: begin
          // The array cannot be stalled, so a missing vector becomes a zero vector and is flagged.
          if (act_valid) begin
            in_w <= act_data;
          end else begin
            err_r[0] <= 1'b1;
          end
          if (scnt == nij_r - 1'b1) begin
            scnt  <= '0;
            state <= S_DRAIN;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end

        S_DRAIN: begin
          if (out_cnt_nxt == nij_r) begin
            state <= S_DONE;
          end
`ifdef MAC_SEQ_WATCHDOG_EN
          else if (dcnt == DCW'(TIMEOUT - 1)) begin
            err_r[1] <= 1'b1;
            state    <= S_DONE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
`endif
        end

        S_DONE: begin
          inst_w <= '0;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_array_seq.sv
// Testbench for mac_array_seq. Each job pushes its hand-computed per-cycle
// output records into a queue. A monitor pops one record on every busy
// cycle and compares it with the DUT outputs.

module tb_mac_array_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic [7:0] nij;
  logic [7:0] wt_data;
  logic       wt_valid;
  logic       wt_ready;
  logic [7:0] act_data;
  logic       act_valid;
  logic       act_ready;
  logic [2:0] inst_w;
  logic [7:0] in_w;
  logic [1:0] valid;
  logic       busy;
  logic       done;
  logic [1:0] err;

  typedef struct packed {
    logic [2:0] inst;
    logic [7:0] d;
    logic       wtr;
    logic       actr;
    logic       dn;
    logic [1:0] e;
  } rec_t;

  rec_t  exp_q[$];
  int    n_total = 0;
  int    n_pass  = 0;
  string cur_tag = "reset";
  int    mon_idx = 0;

  mac_array_seq #(
    .bw(2), .row(2), .col(2), .nij_bw(8), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .nij(nij),
    .wt_data(wt_data), .wt_valid(wt_valid), .wt_ready(wt_ready),
    .act_data(act_data), .act_valid(act_valid), .act_ready(act_ready),
    .inst_w(inst_w), .in_w(in_w), .valid(valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  task automatic rec(input logic [2:0] inst, input logic [7:0] d, input logic wtr,
                     input logic actr, input logic dn, input logic [1:0] e);
    rec_t r;
    r.inst = inst; r.d = d; r.wtr = wtr; r.actr = actr; r.dn = dn; r.e = e;
    exp_q.push_back(r);
  endtask

  // Monitor: one record per busy cycle, sampled on the falling edge.
  initial begin
    rec_t a;
    rec_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        a.inst = inst_w; a.d = in_w; a.wtr = wt_ready; a.actr = act_ready;
        a.dn = done; a.e = err;
        if (exp_q.size() == 0) begin
          check($sformatf("%s extra_busy_cycle", cur_tag), 32'(busy), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s rec%0d {inst,in_w,wtr,actr,done,err}", cur_tag, mon_idx),
                {17'd0, a}, {17'd0, e});
        end
        mon_idx++;
      end
    end
  end

  // Drive one cycle of inputs, then advance to the next falling edge.
  task automatic cyc(input logic s, input logic m, input logic [7:0] n,
                     input logic wv, input logic [7:0] wd,
                     input logic av, input logic [7:0] ad, input logic [1:0] vl);
    start = s; mode = m; nij = n; wt_valid = wv; wt_data = wd;
    act_valid = av; act_data = ad; valid = vl;
    @(negedge clk);
  endtask

  task automatic go(input logic m, input logic [7:0] n);
    cyc(1'b1, m, n, 1'b0, 8'h00, 1'b0, 8'h00, 2'b00);
  endtask

  task automatic wt(input logic v, input logic [7:0] d);
    cyc(1'b0, 1'b0, 8'd0, v, d, 1'b0, 8'h00, 2'b00);
  endtask

  task automatic act(input logic v, input logic [7:0] d, input logic [1:0] vl);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 8'h00, v, d, vl);
  endtask

  task automatic nop(input logic [1:0] vl);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 8'h00, 1'b0, 8'h00, vl);
  endtask

  task automatic begin_job(input string tag);
    cur_tag = tag;
    mon_idx = 0;
    exp_q.delete();
  endtask

  // Wait (bounded) for the job to end, then confirm that every record was consumed.
  task automatic finish_job(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      nop(2'b00);
      n++;
    end
    check({tag, " busy_drops"}, 32'(busy), 32'd0);
    check({tag, " records_left"}, exp_q.size(), 32'd0);
  endtask

  // 2-bit job, nij=1, four weight words with no gaps.
  task automatic job_basic(input string tag);
    begin_job(tag);
    rec(3'b000, 8'h00, 1, 0, 0, 2'b00);
    rec(3'b001, 8'h11, 1, 0, 0, 2'b00);
    rec(3'b001, 8'h22, 1, 0, 0, 2'b00);
    rec(3'b001, 8'h33, 1, 0, 0, 2'b00);
    rec(3'b001, 8'h44, 0, 0, 0, 2'b00);
    rec(3'b000, 8'h00, 0, 0, 0, 2'b00);
    rec(3'b000, 8'h00, 0, 0, 0, 2'b00);
    rec(3'b010, 8'h00, 0, 1, 0, 2'b00);
    rec(3'b000, 8'hA5, 0, 0, 0, 2'b00);
    rec(3'b000, 8'h00, 0, 0, 1, 2'b00);
    go(1'b0, 8'd1);
    wt(1, 8'h11); wt(1, 8'h22); wt(1, 8'h33); wt(1, 8'h44);
    nop(2'b00); nop(2'b00); nop(2'b00);
    act(1, 8'hA5, 2'b00);
    nop(2'b10);
    finish_job(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start = 0; mode = 0; nij = 0; wt_valid = 0; wt_data = 0;
    act_valid = 0; act_data = 0; valid = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset inst_w", 32'(inst_w), 32'd0);
    check("reset in_w", 32'(in_w), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset wt_ready", 32'(wt_ready), 32'd0);
    check("reset act_ready", 32'(act_ready), 32'd0);

    job_basic("basic2b");

    // 4-bit job: two weights. Valid pulses in ARM and STREAM saturate the
    // count at 1, so DRAIN exits on its first cycle.
    begin_job("mode4b");
    rec(3'b000, 8'h00, 1, 0, 0, 2'b00);
    rec(3'b101, 8'h07, 1, 0, 0, 2'b00);
    rec(3'b101, 8'h05, 0, 0, 0, 2'b00);
    rec(3'b100, 8'h00, 0, 0, 0, 2'b00);
    rec(3'b100, 8'h00, 0, 0, 0, 2'b00);
    rec(3'b110, 8'h00, 0, 1, 0, 2'b00);
    rec(3'b100, 8'h0F, 0, 0, 0, 2'b00);
    rec(3'b100, 8'h00, 0, 0, 1, 2'b00);
    go(1'b1, 8'd1);
    wt(1, 8'h07); wt(1, 8'h05);
    nop(2'b00); nop(2'b00);
    nop(2'b10);
    act(1, 8'h0F, 2'b10);
    nop(2'b00);
    finish_job("mode4b");

    // wt_valid is low for 3 cycles in the middle of the load.
    begin_job("wt_stall");
    rec(3'b000, 8'h00, 1, 0, 0, 2'b00);
    rec(3'b001, 8'hA1, 1, 0, 0, 2'b00);
    rec(3'b001, 8'hA2, 1, 0, 0, 2'b00);
    rec(3'b000, 8'h00, 1, 0, 0, 2'b00);
    rec(3'b000, 8'h00, 1, 0, 0, 2'b00);
    rec(3'b000, 8'h00, 1, 0, 0, 2'b00);
    rec(3'b001, 8'hA3, 1, 0, 0, 2'b00);
    rec(3'b001, 8'hA4, 0, 0, 0, 2'b00);
    rec(3'b000, 8'h00, 0, 0, 0, 2'b00);
    rec(3'b000, 8'h00, 0, 0, 0, 2'b00);
    rec(3'b010, 8'h00, 0, 1, 0, 2'b00);
    rec(3'b000, 8'h5A, 0, 0, 0, 2'b00);
    rec(3'b000, 8'h00, 0, 0, 1, 2'b00);
    go(1'b0, 8'd1);
    wt(1, 8'hA1); wt(1, 8'hA2);
    wt(0, 8'hFF); wt(0, 8'hFF); wt(0, 8'hFF);
    wt(1, 8'hA3); wt(1, 8'hA4);
    nop(2'b00); nop(2'b00); nop(2'b00);
    act(1, 8'h5A, 2'b00);
    nop(2'b10);
    finish_job("wt_stall");

    // nij=3 with an activation gap on the 2nd stream cycle; one valid pulse lands during STREAM.
    begin_job("act_gap");
    rec(3'b000, 8'h00, 1, 0, 0, 2'b00);
    rec(3'b001, 8'hB1, 1, 0, 0, 2'b00);
    rec(3'b001, 8'hB2, 1, 0, 0, 2'b00);
    rec(3'b001, 8'hB3, 1, 0, 0, 2'b00);
    rec(3'b001, 8'hB4, 0, 0, 0, 2'b00);
    rec(3'b000, 8'h00, 0, 0, 0, 2'b00);
    rec(3'b000, 8'h00, 0, 0, 0, 2'b00);
    rec(3'b010, 8'h00, 0, 1, 0, 2'b00);
    rec(3'b000, 8'hC1, 0, 1, 0, 2'b00);
    rec(3'b000, 8'h00, 0, 1, 0, 2'b01);
    rec(3'b000, 8'hC3, 0, 0, 0, 2'b01);
    rec(3'b000, 8'h00, 0, 0, 0, 2'b01);
    rec(3'b000, 8'h00, 0, 0, 0, 2'b01);
    rec(3'b000, 8'h00, 0, 0, 1, 2'b01);
    go(1'b0, 8'd3);
    wt(1, 8'hB1); wt(1, 8'hB2); wt(1, 8'hB3); wt(1, 8'hB4);
    nop(2'b00); nop(2'b00); nop(2'b00);
    act(1, 8'hC1, 2'b00);
    act(0, 8'hEE, 2'b00);
    act(1, 8'hC3, 2'b10);
    nop(2'b00); nop(2'b10); nop(2'b10);
    finish_job("act_gap");
    check("act_gap err sticky in idle", 32'(err), 32'd1);

    // Reset in STREAM. A start pulsed mid-load must be ignored: the mode bit stays 0 and the load continues.
    begin_job("reset_mid");
    rec(3'b000, 8'h00, 1, 0, 0, 2'b00);
    rec(3'b001, 8'hD1, 1, 0, 0, 2'b00);
    rec(3'b001, 8'hD2, 1, 0, 0, 2'b00);
    rec(3'b001, 8'hD3, 1, 0, 0, 2'b00);
    rec(3'b001, 8'hD4, 0, 0, 0, 2'b00);
    rec(3'b000, 8'h00, 0, 0, 0, 2'b00);
    rec(3'b000, 8'h00, 0, 0, 0, 2'b00);
    rec(3'b010, 8'h00, 0, 1, 0, 2'b00);
    rec(3'b000, 8'h00, 0, 1, 0, 2'b01);
    go(1'b0, 8'd3);
    wt(1, 8'hD1);
    cyc(1'b1, 1'b1, 8'd5, 1'b1, 8'hD2, 1'b0, 8'h00, 2'b00);
    wt(1, 8'hD3); wt(1, 8'hD4);
    nop(2'b00); nop(2'b00); nop(2'b00);
    act(0, 8'hCC, 2'b00);
    reset = 1'b1;
    act(1, 8'hCC, 2'b00);
    reset = 1'b0;
    check("reset_mid inst_w", 32'(inst_w), 32'd0);
    check("reset_mid in_w", 32'(in_w), 32'd0);
    check("reset_mid busy", 32'(busy), 32'd0);
    check("reset_mid err", 32'(err), 32'd0);
    check("reset_mid act_ready", 32'(act_ready), 32'd0);
    check("reset_mid records_left", exp_q.size(), 32'd0);

    job_basic("after_reset");

    // nij=0: ARM is followed directly by DONE, and act_ready never rises.
    begin_job("nij0");
    rec(3'b000, 8'h00, 1, 0, 0, 2'b00);
    rec(3'b101, 8'hE1, 1, 0, 0, 2'b00);
    rec(3'b101, 8'hE2, 0, 0, 0, 2'b00);
    rec(3'b100, 8'h00, 0, 0, 0, 2'b00);
    rec(3'b100, 8'h00, 0, 0, 0, 2'b00);
    rec(3'b110, 8'h00, 0, 0, 1, 2'b00);
    go(1'b1, 8'd0);
    wt(1, 8'hE1); wt(1, 8'hE2);
    nop(2'b00); nop(2'b00); nop(2'b00);
    finish_job("nij0");

`ifdef MAC_SEQ_WATCHDOG_EN
    // valid is held low: DRAIN gives up after 8 cycles and sets err[1].
    begin_job("watchdog");
    rec(3'b000, 8'h00, 1, 0, 0, 2'b00);
    rec(3'b001, 8'h11, 1, 0, 0, 2'b00);
    rec(3'b001, 8'h22, 1, 0, 0, 2'b00);
    rec(3'b001, 8'h33, 1, 0, 0, 2'b00);
    rec(3'b001, 8'h44, 0, 0, 0, 2'b00);
    rec(3'b000, 8'h00, 0, 0, 0, 2'b00);
    rec(3'b000, 8'h00, 0, 0, 0, 2'b00);
    rec(3'b010, 8'h00, 0, 1, 0, 2'b00);
    rec(3'b000, 8'hA5, 0, 0, 0, 2'b00);
    for (int i = 0; i < 7; i++) rec(3'b000, 8'h00, 0, 0, 0, 2'b00);
    rec(3'b000, 8'h00, 0, 0, 1, 2'b10);
    go(1'b0, 8'd1);
    wt(1, 8'h11); wt(1, 8'h22); wt(1, 8'h33); wt(1, 8'h44);
    nop(2'b00); nop(2'b00); nop(2'b00);
    act(1, 8'hA5, 2'b00);
    finish_job("watchdog");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mac_array_seq.md
Name: mac_array_seq

Overview:
- Sequencer that drives one mac_array instance (array parameters bw, row, col). Sits between the weight/activation buffers and the array.
- Accepts a job command and streams the correct number of weight words into the array with the load bit set.
- Arms execution for one cycle, then streams nij activation vectors.
- Counts array output-valid pulses to detect completion and pulses done.

Parameters:
- bw, 2, operand width of one MAC lane in 2-bit mode
- row, 2, array rows
- col, 2, array columns
- nij_bw, 8, width of the activation-count field
- TIMEOUT, 256, drain watchdog limit in cycles (used only with MAC_SEQ_WATCHDOG_EN)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- start  in  1  job request; sampled only in IDLE
- mode  in  1  0 = 2-bit mode, 1 = 4-bit mode; latched on start accept
- nij  in  nij_bw  number of activation vectors; latched on start accept
- wt_data  in  row*bw*2  weight word
- wt_valid  in  1  weight word available
- wt_ready  out  1  weight word consumed this cycle
- act_data  in  row*bw*2  activation vector
- act_valid  in  1  activation available
- act_ready  out  1  activation consumed this cycle
- inst_w  out  3  to array: {mode, exec, load}
- in_w  out  row*bw*2  to array west input
- valid  in  col  array output-valid bits
- busy  out  1  high from the cycle after start accept through the DONE cycle
- done  out  1  one-cycle completion pulse
- err  out  2  sticky: [0] activation underflow, [1] drain timeout; cleared on start accept

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0. inst_w and in_w are registered.
- WL (weight words per job) = 2*col when mode=0, col when mode=1.
- IDLE:
  - start=1 latches mode and nij, clears err, and moves to LOAD.
  - busy rises in the next cycle.
- LOAD:
  - wt_ready=1.
  - When wt_valid=1: in_w = wt_data, inst_w = {mode,0,1}, and the word count increments.
  - When wt_valid=0: inst_w = {mode,0,0}, in_w = 0, and the count holds (a stall; the array keeps its weights while load is low).
  - After WL accepted words, go to FLUSH.
- FLUSH:
  - Lasts exactly row cycles with inst_w = {mode,0,0} and in_w = 0, so the skewed load can propagate.
  - Then go to ARM.
- ARM:
  - One cycle with inst_w = {mode,1,0} and in_w = 0.
  - Then STREAM, or DONE directly if nij = 0.
- STREAM:
  - Exactly nij cycles with act_ready=1 and inst_w = {mode,0,0}.
  - When act_valid=1: in_w = act_data.
  - When act_valid=0: in_w = 0, err[0] is set, and the cycle still counts. There is no back-pressure into the array.
  - Then go to DRAIN.
- Output counting:
  - From ARM through DRAIN, every cycle with valid[col-1]=1 increments out_cnt. Pulses arriving during STREAM count.
- DRAIN:
  - When out_cnt reaches nij (including reaching it in the same cycle as entry), go to DONE.
- DONE: one cycle with done=1 and busy=1, then IDLE. A start in this cycle is ignored.
- Start while busy: ignored, with no side effects.
- Reset mid-job: on the next edge the FSM is in IDLE, all outputs are 0, and counters are cleared. Partial array state is the array's own reset responsibility.
- Counters saturate at nij. Extra valid pulses after nij are ignored.

Optional Feature:
- MAC_SEQ_WATCHDOG_EN defined:
  - A DRAIN cycle counter runs. If it reaches TIMEOUT cycles before out_cnt = nij, err[1] is set and the FSM goes to DONE (done pulses normally).
- Undefined:
  - DRAIN waits indefinitely.
  - err[1] is tied 0.
  - TIMEOUT is unused.

Test Plan:
- 2-bit job, row=col=2, start mode=0 nij=1, wt_valid always high, 4 weight words:
  - inst_w = 3'b001 for 4 cycles, 3'b000 for 2, 3'b010 for 1, 3'b000 for 1 stream cycle with in_w = act_data.
  - done pulses one cycle after the first valid[1]. busy is high from the cycle after start through the done cycle.
- 4-bit job, mode=1 nij=1:
  - Exactly 2 cycles of inst_w = 3'b101, then 2 of 3'b100, 1 of 3'b110, and 1 stream cycle.
  - With weights 7,5 and activation 15, the array returns 180 and done follows.
- wt_valid low for 3 cycles mid-load (mode=0):
  - load bit low during the gap, LOAD lasts 7 cycles, and exactly 4 words are consumed.
- nij=3 with act_valid low on the 2nd stream cycle:
  - in_w=0 that cycle, err=2'b01, STREAM is still 3 cycles, and done follows after 3 valid[1] pulses.
- Reset in STREAM:
  - Next cycle inst_w=0, busy=0, err=0.
  - A start pulsed while busy earlier had no effect.
  - A new job then completes normally.
- nij=0: ARM followed immediately by DONE, with no act_ready.
- With MAC_SEQ_WATCHDOG_EN, TIMEOUT=8, valid held 0: done pulses after 8 DRAIN cycles with err[1]=1.
